// File: rtl/tt_um_uart_rx_sky25b.sv
// 8N1 serial receiver: samples ui_in[0], presents each byte on uo_out with a
// level valid / ack handshake and valid/frame_err/busy/overrun status on uio_out.
module tt_um_uart_rx_sky25b #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic          ack_meta_q, ack_s_q;
    logic          valid_q, ferr_q, busy_q, overrun_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_meta_q  <= ui_in[0];
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            ack_meta_q <= ui_in[1];
            ack_s_q    <= ack_meta_q;

            // Consumer ack; a same-cycle stop accept below overrides valid.
            if (valid_q && ack_s_q) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        idx_q          <= idx_q + 1'b1;
                        if (idx_q == 3'd7) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            ferr_q  <= 1'b0;
                            if (valid_q && !ack_s_q) overrun_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign uo_out  = data_q;
    assign uio_out = {4'b0000, overrun_q, busy_q, ferr_q, valid_q};
    assign uio_oe  = 8'h0F;

endmodule
